// File: rtl/if_pkg.sv
// Shared defaults and types for the queued instruction fetch stage.
package if_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instruction;
    } fetch_entry_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous, non-fall-through FIFO of fetch entries with a single-cycle flush.
module fetch_queue
    import if_pkg::*;
#(
    parameter int     DEPTH       = 4,
    parameter type    entry_t     = fetch_entry_t,
    parameter entry_t RESET_ENTRY = '0,
    localparam int    CW          = count_width(DEPTH),
    localparam int    PW          = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wr_entry,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_ENTRY;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    no_overflow : assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/stage_if_queued.sv
// Instruction fetch stage: PC register, redirect resolution and a fetch queue
// toward decode. STAGE_IF_PERF_CNT_EN adds pop/redirect performance counters.
module stage_if_queued
    import if_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int              PC_STEP  = 1,
    parameter int              QDEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              control_is_jump,
    input  logic              control_branch_eq,
    input  logic              control_branch_ne,
    input  logic              control_is_zero,
    input  logic [ADDR_W-1:0] data_jump_address,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
    output logic [ADDR_W-1:0] out_pc,
`ifdef STAGE_IF_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_redirects,
`endif
    output logic              is_jumped
);

    localparam int CW = count_width(QDEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instruction;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{pc: RESET_PC, instruction: '0};

    logic              redirect;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    entry_t            head;
    entry_t            wr_entry;

    assign redirect  = control_is_jump
                     | (control_branch_eq &  control_is_zero)
                     | (control_branch_ne & ~control_is_zero);
    assign is_jumped = redirect;

    // Reserve a slot for the in-flight response so a full queue is never overrun.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight);
    assign imem_en   = ~reset & ~redirect & (occupancy < (CW+1)'(QDEPTH));
    assign imem_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                pc <= data_jump_address;
            end else if (imem_en) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
            inflight <= imem_en;
            if (imem_en) begin
                inflight_pc <= pc;
            end
        end
    end

    // A redirect discards the response of the previous cycle's fetch.
    assign push      = inflight & ~redirect;
    assign out_valid = ~empty & ~redirect;
    assign pop       = out_valid & out_ready;
    assign wr_entry  = '{pc: inflight_pc, instruction: imem_rdata};

    fetch_queue #(
        .DEPTH       (QDEPTH),
        .entry_t     (entry_t),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;

`ifdef STAGE_IF_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_if_queued.sv
// Directed bench for stage_if_queued; the memory model returns the read address as data.
module tb_stage_if_queued;

    logic        clock = 1'b0;
    logic        reset;
    logic        control_is_jump;
    logic        control_branch_eq;
    logic        control_branch_ne;
    logic        control_is_zero;
    logic [31:0] data_jump_address;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        is_jumped;
`ifdef STAGE_IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int checks = 0;
    int errors = 0;

    stage_if_queued dut (
        .clock             (clock),
        .reset             (reset),
        .control_is_jump   (control_is_jump),
        .control_branch_eq (control_branch_eq),
        .control_branch_ne (control_branch_ne),
        .control_is_zero   (control_is_zero),
        .data_jump_address (data_jump_address),
        .imem_en           (imem_en),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instruction   (out_instruction),
        .out_pc            (out_pc),
`ifdef STAGE_IF_PERF_CNT_EN
        .perf_fetched      (perf_fetched),
        .perf_redirects    (perf_redirects),
`endif
        .is_jumped         (is_jumped)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (imem_en) begin
            imem_rdata <= imem_addr;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic ready);
        reset     = 1'b1;
        out_ready = ready;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        control_is_jump   = 1'b0;
        control_branch_eq = 1'b0;
        control_branch_ne = 1'b0;
        control_is_zero   = 1'b0;
        data_jump_address = '0;
        out_ready         = 1'b1;
        step();
        step();

        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_imem_en", 64'(imem_en), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_instr", 64'(out_instruction), 64'd0);
        check("rst_is_jumped", 64'(is_jumped), 64'd0);

        // back-to-back streaming
        reset = 1'b0;
        #1;
        check("bb_c0_en", 64'(imem_en), 64'd1);
        check("bb_c0_addr", 64'(imem_addr), 64'd0);
        check("bb_c0_valid", 64'(out_valid), 64'd0);
        step();
        check("bb_c1_valid", 64'(out_valid), 64'd0);
        check("bb_c1_addr", 64'(imem_addr), 64'd1);
        step();
        check("bb_c2_valid", 64'(out_valid), 64'd1);
        check("bb_c2_pc", 64'(out_pc), 64'd0);
        check("bb_c2_instr", 64'(out_instruction), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("bb_valid", 64'(out_valid), 64'd1);
            check("bb_pc", 64'(out_pc), 64'(k));
            check("bb_instr", 64'(out_instruction), 64'(k));
        end

        // decode stall fills the queue
        restart(1'b0);
        repeat (4) step();
        check("stall_c4_en", 64'(imem_en), 64'd0);
        check("stall_c4_valid", 64'(out_valid), 64'd1);
        repeat (6) step();
        check("stall_c10_en", 64'(imem_en), 64'd0);
        check("stall_c10_addr", 64'(imem_addr), 64'd4);
        out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_pc", 64'(out_pc), 64'(k));
            check("drain_instr", 64'(out_instruction), 64'(k));
            step();
        end

        // jump with 3 queued and one read in flight
        restart(1'b0);
        repeat (4) step();
        check("jmp_pre_valid", 64'(out_valid), 64'd1);
        control_is_jump   = 1'b1;
        data_jump_address = 32'h40;
        #1;
        check("jmp_is_jumped", 64'(is_jumped), 64'd1);
        check("jmp_valid", 64'(out_valid), 64'd0);
        check("jmp_en", 64'(imem_en), 64'd0);
        step();
        control_is_jump = 1'b0;
        out_ready       = 1'b1;
        #1;
        check("jmp_n1_addr", 64'(imem_addr), 64'h40);
        check("jmp_n1_en", 64'(imem_en), 64'd1);
        check("jmp_n1_valid", 64'(out_valid), 64'd0);
        step();
        check("jmp_n2_valid", 64'(out_valid), 64'd0);
        step();
        check("jmp_n3_valid", 64'(out_valid), 64'd1);
        check("jmp_n3_pc", 64'(out_pc), 64'h40);
        check("jmp_n3_instr", 64'(out_instruction), 64'h40);
        step();
        check("jmp_n4_pc", 64'(out_pc), 64'h41);
        step();

        // branch truth table
        control_branch_eq = 1'b1; control_is_zero = 1'b1; #1;
        check("beq_z1", 64'(is_jumped), 64'd1);
        control_is_zero = 1'b0; #1;
        check("beq_z0", 64'(is_jumped), 64'd0);
        control_branch_eq = 1'b0; control_branch_ne = 1'b1; control_is_zero = 1'b1; #1;
        check("bne_z1", 64'(is_jumped), 64'd0);
        control_is_zero = 1'b0; #1;
        check("bne_z0", 64'(is_jumped), 64'd1);
        control_branch_ne = 1'b0; control_branch_eq = 1'b1; control_is_zero = 1'b1;
        data_jump_address = 32'h80; #1;
        check("beq_taken", 64'(is_jumped), 64'd1);
        check("beq_valid", 64'(out_valid), 64'd0);
        step();
        control_branch_eq = 1'b0; control_branch_ne = 1'b1; control_is_zero = 1'b1;
        data_jump_address = 32'h200; #1;
        check("bne_nt_jumped", 64'(is_jumped), 64'd0);
        check("beq_tgt_addr", 64'(imem_addr), 64'h80);
        check("beq_tgt_en", 64'(imem_en), 64'd1);
        step();
        control_branch_ne = 1'b0; control_is_zero = 1'b0;
        check("bne_nt_addr", 64'(imem_addr), 64'h81);
        check("bne_nt_valid", 64'(out_valid), 64'd0);
        step();
        check("br_first_valid", 64'(out_valid), 64'd1);
        check("br_first_pc", 64'(out_pc), 64'h80);

        // redirect coincident with a would-be pop
        restart(1'b1);
        step();
        step();
        check("co_c2_pc", 64'(out_pc), 64'd0);
        step();
        check("co_c3_valid", 64'(out_valid), 64'd1);
        check("co_c3_pc", 64'(out_pc), 64'd1);
`ifdef STAGE_IF_PERF_CNT_EN
        check("perf_fetch_pre", 64'(perf_fetched), 64'd1);
        check("perf_redir_pre", 64'(perf_redirects), 64'd0);
`endif
        control_is_jump   = 1'b1;
        data_jump_address = 32'h100;
        #1;
        check("co_valid", 64'(out_valid), 64'd0);
        check("co_is_jumped", 64'(is_jumped), 64'd1);
        step();
        control_is_jump = 1'b0;
        #1;
`ifdef STAGE_IF_PERF_CNT_EN
        check("perf_fetch_post", 64'(perf_fetched), 64'd1);
        check("perf_redir_post", 64'(perf_redirects), 64'd1);
`endif
        check("co_n1_addr", 64'(imem_addr), 64'h100);
        check("co_n1_valid", 64'(out_valid), 64'd0);
        step();
        check("co_n2_valid", 64'(out_valid), 64'd0);
        step();
        check("co_n3_valid", 64'(out_valid), 64'd1);
        check("co_n3_pc", 64'(out_pc), 64'h100);
        check("co_n3_instr", 64'(out_instruction), 64'h100);

        // asynchronous reset with a full queue
        out_ready = 1'b0;
        repeat (6) step();
        check("full_en", 64'(imem_en), 64'd0);
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_head", 64'(out_pc), 64'h100);
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_en", 64'(imem_en), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("rel_en", 64'(imem_en), 64'd1);
        check("rel_addr", 64'(imem_addr), 64'd0);
        step();
        step();
        check("rel_valid", 64'(out_valid), 64'd1);
        check("rel_pc", 64'(out_pc), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
